adder_eval_engine: RTL and testbench
====================================

# adder_eval_engine

Parametrised, self-running error-evaluation engine for approximate adders. It generates operand vectors (exhaustive or LFSR), drives them into an externally instantiated W-bit approximate adder, and compares each result against the exact sum. It accumulates error count, sum of absolute error and maximum error distance. It replaces file-driven testbench stimulus as the on-chip/in-sim measurement front end for the error-evaluation flow, and supports pipelined DUTs.

## Interface
- `W`, default 2: operand width; DUT has 2W inputs and W+1 outputs; 1 ≤ W ≤ 16.
- `LAT`, default 0: DUT latency in cycles from `dut_pi` to valid `dut_po`; 0 = combinational.
- `N_W`, default 16: width of vector count and error count.
- `ACC_W`, default 32: width of the absolute-error accumulator.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `mode` in 1: 0 = exhaustive counter, 1 = LFSR; sampled with `start`.
- `seed` in 32: LFSR seed, sampled with `start`; 0 is replaced by 1.
- `num_vec` in N_W: number of vectors to issue, sampled with `start`.
- `dut_pi` out 2W: registered operands; a = [W-1:0], b = [2W-1:W].
- `dut_po` in W+1: DUT sum.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of run.
- `vec_cnt` out N_W: vectors compared so far.
- `err_cnt` out N_W: vectors with `dut_po` ≠ a+b.
- `err_sum` out ACC_W: Σ|dut_po − (a+b)|, saturating at all-ones.
- `err_max` out W+1: max |dut_po − (a+b)|.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE: when `start` = 1, clear all statistics and latch `mode`, `seed` and `num_vec`.
  - If `num_vec` = 0, go to DONE.
  - Otherwise load vector 0 into `dut_pi` and go to RUN.
- RUN: each cycle, load the next vector. After `num_vec` vectors have been issued:
  - go to DRAIN if LAT > 0,
  - otherwise go to DONE once the last comparison is accumulated.
- DRAIN: wait until all LAT in-flight vectors have been compared, then go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. Statistics hold until the next accepted `start`.
- Exhaustive mode: vector k = k mod 2^(2W); values wrap and repeat if `num_vec` > 2^(2W).
- LFSR mode: 32-bit Galois LFSR, polynomial `0x80200003`. Vector = low 2W bits of the state. The LFSR steps once per issued vector.
- Comparison path:
  - The exact sum a+b (W+1 bits) and a valid bit travel through a LAT-deep delay line alongside the DUT.
  - When the delayed valid = 1, `vec_cnt` increments. If `dut_po` ≠ exact, `err_cnt` increments.
  - The absolute error is computed in W+2 bits, zero-extended into `err_sum` (saturating) and max-compared into `err_max`.
- `start` while `busy` or in DONE: ignored.
- Reset, including mid-run: state IDLE; `dut_pi`, all statistics, `busy`, `done`, LFSR and delay line all go to 0.

## Timing
- The edge that samples `start` loads vector 0; `busy` is high from the next cycle.
- Vector i on `dut_pi` is compared in the cycle that is LAT cycles later. Counters update on the following edge.
- For `num_vec` = N > 0, `done` is high exactly N+LAT+1 cycles after the sampling edge. `busy` falls in the same cycle `done` rises.
- For `num_vec` = 0, `done` is high 1 cycle after the sampling edge and `busy` never rises.
- Final statistics are valid in the `done` cycle.
- Throughput is one vector per cycle; there are no stalls.

## Structure
- Package `adder_eval_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE),
  - `LFSR_POLY` = 32'h80200003,
  - an `abs_diff` function,
  - the saturating-add function.
- Sub-module `adder_eval_lfsr` (32-bit Galois LFSR with load/step/zero-seed fix). Everything else stays in the top module.

## Test plan
All scenarios use W=2, LAT=0 unless stated.
- Exact DUT (po = a+b), mode 0, `num_vec` = 16 -> `vec_cnt` = 16, `err_cnt` = 0, `err_sum` = 0, `err_max` = 0; `done` 17 cycles after start.
- DUT with po[0] tied 0, mode 0, `num_vec` = 16 -> `err_cnt` = 8, `err_sum` = 8, `err_max` = 1.
- DUT with po[2] tied 0, mode 0, `num_vec` = 16 -> `err_cnt` = 6, `err_sum` = 24, `err_max` = 4.
- LAT=2, exact DUT registered twice, `num_vec` = 16 -> zero errors, `done` 19 cycles after start.
- Zero seed:
  - mode 1, `seed` = 0, `num_vec` = 100, run twice -> identical statistics to `seed` = 1.
  - `num_vec` = 0 -> `done` after 1 cycle, all statistics 0.
- Control corner cases:
  - `rst` asserted at vector 5 of 16 -> all outputs 0 asynchronously, FSM in IDLE.
  - `start` pulsed while `busy` -> no effect on the statistics.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for the approximate-adder error-evaluation engine.
// Holds the FSM state type, LFSR polynomial and error arithmetic helpers.
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Widest operand the engine supports; helpers are sized for it.
    localparam int MAX_W = 16;

    function automatic logic [MAX_W+1:0] abs_diff(
        input logic [MAX_W+1:0] x,
        input logic [MAX_W+1:0] y
    );
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [63:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input logic [63:0] lim
    );
        logic [63:0] s;
        s = acc + inc;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/adder_eval_if.sv
// Control/status bundle of the evaluation engine plus the adder-under-test
// operand and result lines.
interface adder_eval_if #(
    parameter int W     = 2,
    parameter int N_W   = 16,
    parameter int ACC_W = 32
);
    logic             start;
    logic             mode;
    logic [31:0]      seed;
    logic [N_W-1:0]   num_vec;
    logic [2*W-1:0]   dut_pi;
    logic [W:0]       dut_po;
    logic             busy;
    logic             done;
    logic [N_W-1:0]   vec_cnt;
    logic [N_W-1:0]   err_cnt;
    logic [ACC_W-1:0] err_sum;
    logic [W:0]       err_max;

    modport master (
        output start, mode, seed, num_vec, dut_po,
        input  dut_pi, busy, done, vec_cnt, err_cnt, err_sum, err_max
    );

    modport slave (
        input  start, mode, seed, num_vec, dut_po,
        output dut_pi, busy, done, vec_cnt, err_cnt, err_sum, err_max
    );
endinterface

// File: rtl/adder_eval_lfsr.sv
// 32-bit Galois LFSR operand source. The value presented on vec is the one
// issued this cycle; a load presents the (non-zero) seed immediately.
module adder_eval_lfsr
    import adder_eval_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      seed,
    output logic [OUT_W-1:0] vec
);
    logic [31:0] state;
    logic [31:0] cur;

    // A zero seed would lock the register, so it is replaced by 1.
    assign cur = load ? ((seed == '0) ? 32'd1 : seed) : state;
    assign vec = cur[OUT_W-1:0];

    // Advance past the value just issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load || step) begin
            state <= {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'd0);
        end
    end
endmodule

// File: rtl/adder_eval_engine.sv
// Self-running error-evaluation engine: issues operand vectors to an external
// approximate adder and accumulates error statistics against the exact sum.
module adder_eval_engine
    import adder_eval_pkg::*;
#(
    parameter int W     = 2,
    parameter int LAT   = 0,
    parameter int N_W   = 16,
    parameter int ACC_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    adder_eval_if.slave bus
);
    localparam int VW = 2 * W;
    localparam logic [63:0] SAT_LIM = 64'({ACC_W{1'b1}});

    state_t         state;
    logic           mode_q;
    logic [N_W-1:0] num_q;
    logic [N_W-1:0] issued;
    logic [VW-1:0]  cnt;
    logic [VW-1:0]  cnt_cur;
    logic [VW-1:0]  pi;
    logic [VW-1:0]  vec;
    logic [VW-1:0]  lfsr_vec;
    logic           pi_vld;
    logic           busy_q;
    logic           done_q;
    logic           accept;
    logic           issue_first;
    logic           issue_next;
    logic           issue;
    logic           use_lfsr;
    logic [W:0]     exact_now;
    logic [W:0]     exact_cmp;
    logic           cmp_vld;
    logic           pending;
    logic [MAX_W+1:0] ad_full;

    logic [N_W-1:0]   vec_cnt_q;
    logic [N_W-1:0]   err_cnt_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [W:0]       err_max_q;

    assign accept      = (state == IDLE) && bus.start;
    assign issue_first = accept && (bus.num_vec != '0);
    assign issue_next  = (state == RUN) && (issued != num_q);
    assign issue       = issue_first || issue_next;
    assign use_lfsr    = issue_first ? bus.mode : mode_q;
    assign cnt_cur     = issue_first ? '0 : cnt;
    assign vec         = use_lfsr ? lfsr_vec : cnt_cur;

    adder_eval_lfsr #(
        .OUT_W(VW)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .load(issue_first),
        .step(issue_next && mode_q),
        .seed(bus.seed),
        .vec (lfsr_vec)
    );

    // Exhaustive operand counter; wraps naturally at 2^(2W).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= cnt_cur + 1'b1;
        end
    end

    assign exact_now = {1'b0, pi[W-1:0]} + {1'b0, pi[VW-1:W]};

    if (LAT == 0) begin : g_comb
        assign cmp_vld   = pi_vld;
        assign exact_cmp = exact_now;
        assign pending   = 1'b0;
    end else begin : g_pipe
        logic [LAT-1:0] dv;
        logic [W:0]     dsum [LAT];

        // Exact sum and valid bit ride alongside the external adder pipeline.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dv <= '0;
                for (int k = 0; k < LAT; k++) dsum[k] <= '0;
            end else begin
                dv[0]   <= pi_vld;
                dsum[0] <= exact_now;
                for (int k = 1; k < LAT; k++) begin
                    dv[k]   <= dv[k-1];
                    dsum[k] <= dsum[k-1];
                end
            end
        end

        // Still waiting if anything sits ahead of the compare stage.
        always_comb begin
            pending = 1'b0;
            for (int k = 0; k < LAT - 1; k++) pending = pending | dv[k];
        end

        assign cmp_vld   = dv[LAT-1];
        assign exact_cmp = dsum[LAT-1];
    end

    assign ad_full = abs_diff((MAX_W+2)'(bus.dut_po), (MAX_W+2)'(exact_cmp));

    // Run control: sequencing, operand register and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pi     <= '0;
            pi_vld <= 1'b0;
            mode_q <= 1'b0;
            num_q  <= '0;
            issued <= '0;
        end else begin
            done_q <= 1'b0;
            pi_vld <= issue;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        num_q  <= bus.num_vec;
                        if (bus.num_vec == '0) begin
                            issued <= '0;
                            state  <= DONE;
                        end else begin
                            pi     <= vec;
                            issued <= N_W'(1);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued != num_q) begin
                        pi     <= vec;
                        issued <= issued + 1'b1;
                    end else begin
                        state <= (LAT == 0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pending) state <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Statistics: cleared on an accepted start, updated per compared vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (accept) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (cmp_vld) begin
            vec_cnt_q <= vec_cnt_q + 1'b1;
            if (bus.dut_po != exact_cmp) err_cnt_q <= err_cnt_q + 1'b1;
            err_sum_q <= ACC_W'(sat_add(64'(err_sum_q), 64'(ad_full), SAT_LIM));
            if (ad_full > (MAX_W+2)'(err_max_q)) err_max_q <= ad_full[W:0];
        end
    end

    assign bus.dut_pi  = pi;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.vec_cnt = vec_cnt_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.err_sum = err_sum_q;
    assign bus.err_max = err_max_q;
endmodule

// File: tb/tb_adder_eval_engine.sv
// Scoreboard bench for adder_eval_engine: a combinational (LAT=0) and a
// two-stage registered (LAT=2) approximate adder, each with selectable fault.
module tb_adder_eval_engine;
    localparam int W = 2;
    localparam logic [31:0] POLY = 32'h80200003;

    typedef struct {
        int     vec;
        int     err;
        longint sum;
        int     mx;
        int     t_done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   f0 = 0;
    int   f2 = 0;
    exp_t q0[$];
    exp_t q2[$];
    logic [2:0] r1, r2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_eval_if #(.W(W), .N_W(16), .ACC_W(32)) bus0 ();
    adder_eval_if #(.W(W), .N_W(16), .ACC_W(32)) bus2 ();

    adder_eval_engine #(.W(W), .LAT(0), .N_W(16), .ACC_W(32)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    adder_eval_engine #(.W(W), .LAT(2), .N_W(16), .ACC_W(32)) u2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Approximate adder behaviour: 0 exact, 1 po[0]=0, 2 po[2]=0, 3 a|b.
    function automatic int fault_po(int f, int v);
        int a, b, s;
        a = v % 4;
        b = (v / 4) % 4;
        s = a + b;
        case (f)
            1: return s & 6;
            2: return s & 3;
            3: return a | b;
            default: return s;
        endcase
    endfunction

    always_comb bus0.dut_po = 3'(fault_po(f0, int'(bus0.dut_pi)));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= '0;
            r2 <= '0;
        end else begin
            r1 <= 3'(fault_po(f2, int'(bus2.dut_pi)));
            r2 <= r1;
        end
    end
    assign bus2.dut_po = r2;

    function automatic exp_t model(int mode, int unsigned seed, int n,
                                   int f, int lat, int t0);
        exp_t e;
        int unsigned s;
        int v, ex, po, d;
        e = '{default: 0};
        s = (seed == 0) ? 1 : seed;
        for (int k = 0; k < n; k++) begin
            if (mode != 0) begin
                v = int'(s % 16);
                s = (s >> 1) ^ (((s & 1) != 0) ? POLY : 32'd0);
            end else begin
                v = k % 16;
            end
            ex = (v % 4) + (v / 4);
            po = fault_po(f, v);
            d  = (po > ex) ? po - ex : ex - po;
            e.vec++;
            if (d != 0) e.err++;
            e.sum += d;
            if (d > e.mx) e.mx = d;
        end
        e.vec = e.vec % 65536;
        e.err = e.err % 65536;
        if (e.sum > 64'hFFFF_FFFF) e.sum = 64'hFFFF_FFFF;
        e.t_done = t0 + n + ((n != 0) ? lat : 0) + 1;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic score(string tag, exp_t e, logic [15:0] vc,
                         logic [15:0] ec, logic [31:0] es,
                         logic [2:0] em, logic b);
        chk({tag, "_vec_cnt"}, 64'(vc), 64'(e.vec));
        chk({tag, "_err_cnt"}, 64'(ec), 64'(e.err));
        chk({tag, "_err_sum"}, 64'(es), 64'(e.sum));
        chk({tag, "_err_max"}, 64'(em), 64'(e.mx));
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.t_done));
        chk({tag, "_busy_at_done"}, 64'(b), 64'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus0.done === 1'b1) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL u0_unexpected_done: got 1 expected 0");
                end else begin
                    e = q0.pop_front();
                    score("u0", e, bus0.vec_cnt, bus0.err_cnt,
                          bus0.err_sum, bus0.err_max, bus0.busy);
                end
            end
            if (bus2.done === 1'b1) begin
                if (q2.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL u2_unexpected_done: got 1 expected 0");
                end else begin
                    e = q2.pop_front();
                    score("u2", e, bus2.vec_cnt, bus2.err_cnt,
                          bus2.err_sum, bus2.err_max, bus2.busy);
                end
            end
        end
    end

    task automatic drive(int d, logic st, int mode, int unsigned seed, int n);
        if (d == 0) begin
            bus0.start   = st;
            bus0.mode    = mode[0];
            bus0.seed    = seed;
            bus0.num_vec = 16'(n);
        end else begin
            bus2.start   = st;
            bus2.mode    = mode[0];
            bus2.seed    = seed;
            bus2.num_vec = 16'(n);
        end
    endtask

    task automatic kick(int d, int mode, int unsigned seed, int n,
                        output int t0);
        @(negedge clk);
        drive(d, 1'b1, mode, seed, n);
        @(negedge clk);
        drive(d, 1'b0, 0, 0, 0);
        t0 = cyc;
    endtask

    task automatic run(int d, int mode, int unsigned seed, int n, int f);
        int t0;
        if (d == 0) f0 = f;
        else f2 = f;
        kick(d, mode, seed, n, t0);
        if (d == 0) begin
            q0.push_back(model(mode, seed, n, f, 0, t0));
            chk("u0_busy_after_start", 64'(bus0.busy), 64'(n != 0));
        end else begin
            q2.push_back(model(mode, seed, n, f, 2, t0));
            chk("u2_busy_after_start", 64'(bus2.busy), 64'(n != 0));
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((q0.size() != 0 || q2.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q2.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0",
                     q0.size() + q2.size());
            q0.delete();
            q2.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(string tag, logic [3:0] pi, logic b, logic dn,
                            logic [15:0] vc, logic [15:0] ec,
                            logic [31:0] es, logic [2:0] em);
        chk({tag, "_dut_pi"}, 64'(pi), 64'd0);
        chk({tag, "_busy"}, 64'(b), 64'd0);
        chk({tag, "_done"}, 64'(dn), 64'd0);
        chk({tag, "_vec_cnt"}, 64'(vc), 64'd0);
        chk({tag, "_err_cnt"}, 64'(ec), 64'd0);
        chk({tag, "_err_sum"}, 64'(es), 64'd0);
        chk({tag, "_err_max"}, 64'(em), 64'd0);
    endtask

    initial begin
        int t0;
        drive(0, 1'b0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_zero("rst_u0", bus0.dut_pi, bus0.busy, bus0.done, bus0.vec_cnt,
                 bus0.err_cnt, bus0.err_sum, bus0.err_max);
        chk_zero("rst_u2", bus2.dut_pi, bus2.busy, bus2.done, bus2.vec_cnt,
                 bus2.err_cnt, bus2.err_sum, bus2.err_max);
        rst = 1'b0;

        run(0, 0, 0, 16, 0);
        wait_drain();
        run(0, 0, 0, 16, 1);
        wait_drain();
        run(0, 0, 0, 16, 2);
        wait_drain();
        run(2, 0, 0, 16, 0);
        wait_drain();
        run(2, 0, 0, 16, 2);
        wait_drain();

        for (int i = 0; i < 2; i++) begin
            run(0, 1, 0, 100, 3);
            wait_drain();
        end
        run(0, 1, 1, 100, 3);
        wait_drain();

        run(0, 0, 0, 0, 0);
        run(2, 1, 5, 0, 1);
        wait_drain();

        // Asynchronous reset while vector 5 is on the operand bus.
        f0 = 2;
        kick(0, 0, 0, 16, t0);
        repeat (5) @(negedge clk);
        chk("mid_vec_cnt", 64'(bus0.vec_cnt), 64'd5);
        chk("mid_dut_pi", 64'(bus0.dut_pi), 64'd5);
        #1 rst = 1'b1;
        #1;
        chk_zero("arst_u0", bus0.dut_pi, bus0.busy, bus0.done, bus0.vec_cnt,
                 bus0.err_cnt, bus0.err_sum, bus0.err_max);
        @(negedge clk);
        rst = 1'b0;
        run(0, 0, 0, 5, 1);
        wait_drain();

        // A start pulse during a run must be ignored.
        run(0, 0, 0, 16, 2);
        run(2, 0, 0, 16, 3);
        repeat (4) @(negedge clk);
        drive(0, 1'b1, 1, 7, 3);
        drive(2, 1'b1, 1, 7, 3);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0);
        wait_drain();

        for (int i = 0; i < 12; i++) begin
            run(0, int'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(1, 70)), int'($urandom_range(0, 3)));
            run(2, int'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(1, 70)), int'($urandom_range(0, 3)));
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
